// File: rtl/wbm_cmd_master_pkg.sv
// ---------------------------------------------------------------------------
// wbm_cmd_master_pkg
//
// Shared WISHBONE bus widths, response status codes and small helpers for
// the command-driven WISHBONE classic master (wbm_cmd_master).
//
// Contents:
//   WB_ADR_W / WB_DAT_W / WB_SEL_W  word address, data and byte-select widths
//   STATUS_*                        2-bit completion codes on rsp_status_o
//   wb_cmd_t                        one captured command (we/adr/dat/sel)
//   status_is_fail()                true for every non-ACK completion
//   sat_inc16()                     16-bit increment that sticks at 0xFFFF
// ---------------------------------------------------------------------------
package wbm_cmd_master_pkg;

    // WISHBONE widths used on the command port and on the bus itself.
    localparam int WB_ADR_W = 22;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    // Completion codes reported with every response.
    localparam logic [1:0] STATUS_ACK             = 2'b00;
    localparam logic [1:0] STATUS_ERR             = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT         = 2'b10;
    localparam logic [1:0] STATUS_RETRY_EXHAUSTED = 2'b11;

    // A command as it is held for the whole life of a transaction,
    // including every retry reissue.
    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_cmd_t;

    // Any status other than ACK counts as a failed command.
    function automatic logic status_is_fail(input logic [1:0] status);
        return (status != STATUS_ACK);
    endfunction

    // Saturating increment for the failure counter; it must never wrap.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/wbm_cmd_master.sv
// ---------------------------------------------------------------------------
// wbm_cmd_master
//
// Turns single commands from a valid/ready command port into WISHBONE
// classic single cycles, handles ERR/RTY/ACK terminations, retries with a
// back-off gap, aborts stuck phases after a timeout, and returns one
// response per accepted command on a valid/ready response port.
//
// Parameters:
//   TIMEOUT_CYCLES  1..65535  BUS cycles without termination before abort
//   MAX_RETRY       >= 0      RTY-triggered reissues allowed per command
//   RETRY_BACKOFF   1..255    CYC-low cycles between an RTY and the reissue
//
// Ports:
//   clk_i, rst_n_i                    clock, async active-low reset
//   cmd_valid_i / cmd_ready_o         command handshake
//   cmd_we_i, cmd_adr_i, cmd_dat_i,   command write flag, word address,
//   cmd_sel_i                         write data, byte selects
//   rsp_valid_o / rsp_ready_i         response handshake
//   rsp_dat_o                         read data (0 for writes and failures)
//   rsp_status_o                      00 ACK, 01 ERR, 10 TIMEOUT,
//                                     11 RETRY_EXHAUSTED
//   cyc_o, stb_o, we_o, adr_o,        registered WISHBONE master outputs
//   dat_o, sel_o
//   dat_i, ack_i, err_i, rty_i        WISHBONE return path
//   fail_count_o                      saturating count of non-ACK completions
//
// States: IDLE waits for a command, BUS drives the cycle, BACKOFF keeps CYC
// low between a retry and its reissue, RESP holds the response until taken.
// ---------------------------------------------------------------------------
module wbm_cmd_master
    import wbm_cmd_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRY      = 3,
    parameter int RETRY_BACKOFF  = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,

    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [WB_ADR_W-1:0] cmd_adr_i,
    input  logic [WB_DAT_W-1:0] cmd_dat_i,
    input  logic [WB_SEL_W-1:0] cmd_sel_i,

    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [WB_DAT_W-1:0] rsp_dat_o,
    output logic [1:0]          rsp_status_o,

    output logic                cyc_o,
    output logic                stb_o,
    output logic                we_o,
    output logic [WB_ADR_W-1:0] adr_o,
    output logic [WB_DAT_W-1:0] dat_o,
    output logic [WB_SEL_W-1:0] sel_o,
    input  logic [WB_DAT_W-1:0] dat_i,
    input  logic                ack_i,
    input  logic                err_i,
    input  logic                rty_i,

    output logic [15:0]         fail_count_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUS     = 2'd1;
    localparam logic [1:0] ST_BACKOFF = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] RETRY_LIMIT   = 16'(MAX_RETRY);
    localparam logic [15:0] BACKOFF_LAST  = 16'(RETRY_BACKOFF - 1);

    logic [1:0]          state;
    wb_cmd_t             cmd_q;
    logic [15:0]         cnt;        // timeout count in BUS, gap count in BACKOFF
    logic [15:0]         retry_cnt;
    logic [15:0]         cnt_inc;

    logic                finish;
    logic                go_backoff;
    logic [1:0]          finish_status;
    logic [WB_DAT_W-1:0] finish_dat;

    // The bus address/data/select/we are straight register outputs of the
    // captured command, so they stay put across BACKOFF and every reissue.
    assign we_o  = cmd_q.we;
    assign adr_o = cmd_q.adr;
    assign dat_o = cmd_q.dat;
    assign sel_o = cmd_q.sel;

    assign cnt_inc = cnt + 16'd1;

    // Decide how the current BUS cycle ends. ERR beats RTY beats ACK, and
    // any termination beats a timeout reached in the same cycle. The timeout
    // fires on the cycle whose increment would reach the limit, so CYC stays
    // high for exactly TIMEOUT_CYCLES bus cycles.
    always_comb begin
        finish        = 1'b0;
        go_backoff    = 1'b0;
        finish_status = STATUS_ACK;
        finish_dat    = '0;
        if (state == ST_BUS) begin
            if (err_i) begin
                finish        = 1'b1;
                finish_status = STATUS_ERR;
            end else if (rty_i) begin
                if (retry_cnt < RETRY_LIMIT) begin
                    go_backoff = 1'b1;
                end else begin
                    finish        = 1'b1;
                    finish_status = STATUS_RETRY_EXHAUSTED;
                end
            end else if (ack_i) begin
                finish        = 1'b1;
                finish_status = STATUS_ACK;
                finish_dat    = cmd_q.we ? '0 : dat_i;
            end else if (cnt_inc == TIMEOUT_LIMIT) begin
                finish        = 1'b1;
                finish_status = STATUS_TIMEOUT;
            end
        end
    end

    // Main controller. cmd_ready_o is a register so that it comes up one
    // clock after reset release rather than during reset. Reset drops CYC
    // at once and throws away any command in flight without a response.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_IDLE;
            cmd_q        <= '0;
            cnt          <= '0;
            retry_cnt    <= '0;
            cmd_ready_o  <= 1'b0;
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_dat_o    <= '0;
            rsp_status_o <= STATUS_ACK;
            fail_count_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (cmd_ready_o && cmd_valid_i) begin
                        cmd_q.we    <= cmd_we_i;
                        cmd_q.adr   <= cmd_adr_i;
                        cmd_q.dat   <= cmd_we_i ? cmd_dat_i : '0;
                        cmd_q.sel   <= cmd_sel_i;
                        cnt         <= '0;
                        retry_cnt   <= '0;
                        cmd_ready_o <= 1'b0;
                        cyc_o       <= 1'b1;
                        stb_o       <= 1'b1;
                        state       <= ST_BUS;
                    end
                end

                ST_BUS: begin
                    if (finish) begin
                        cyc_o        <= 1'b0;
                        stb_o        <= 1'b0;
                        rsp_valid_o  <= 1'b1;
                        rsp_status_o <= finish_status;
                        rsp_dat_o    <= finish_dat;
                        if (status_is_fail(finish_status)) begin
                            fail_count_o <= sat_inc16(fail_count_o);
                        end
                        state        <= ST_RESP;
                    end else if (go_backoff) begin
                        cyc_o     <= 1'b0;
                        stb_o     <= 1'b0;
                        retry_cnt <= retry_cnt + 16'd1;
                        cnt       <= '0;
                        state     <= ST_BACKOFF;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                ST_BACKOFF: begin
                    if (cnt == BACKOFF_LAST) begin
                        cnt   <= '0;
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        state <= ST_BUS;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbm_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_wbm_cmd_master
//
// Self-checking bench for wbm_cmd_master with default parameters. A slave
// process answers each bus phase according to a per-attempt script; a
// reference model derives the expected phases, gaps, latency, status, data
// and failure count from that same script.
// ---------------------------------------------------------------------------
module tb_wbm_cmd_master;
    import wbm_cmd_master_pkg::*;

    localparam int TIMEOUT = 255;
    localparam int MAXR    = 3;
    localparam int BACKOFF = 4;

    localparam int K_NONE   = 0;
    localparam int K_ACK    = 1;
    localparam int K_ERR    = 2;
    localparam int K_RTY    = 3;
    localparam int K_ERRACK = 4;
    localparam int K_RTYACK = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we = 1'b0;
    logic [21:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid_o;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat_o;
    logic [1:0]  rsp_status_o;
    logic        cyc_o, stb_o, we_o;
    logic [21:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i = '0;
    logic        ack_i, err_i, rty_i;
    logic [15:0] fail_count_o;

    logic s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0, inj_ack = 1'b0;
    assign ack_i = s_ack | inj_ack;
    assign err_i = s_err;
    assign rty_i = s_rty;

    wbm_cmd_master #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .MAX_RETRY     (MAXR),
        .RETRY_BACKOFF (BACKOFF)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_we_i     (cmd_we),
        .cmd_adr_i    (cmd_adr),
        .cmd_dat_i    (cmd_dat),
        .cmd_sel_i    (cmd_sel),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready),
        .rsp_dat_o    (rsp_dat_o),
        .rsp_status_o (rsp_status_o),
        .cyc_o        (cyc_o),
        .stb_o        (stb_o),
        .we_o         (we_o),
        .adr_o        (adr_o),
        .dat_o        (dat_o),
        .sel_o        (sel_o),
        .dat_i        (dat_i),
        .ack_i        (ack_i),
        .err_i        (err_i),
        .rty_i        (rty_i),
        .fail_count_o (fail_count_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Slave script: what happens on each bus attempt of the current command.
    int          s_kind [8];
    int          s_dly  [8];
    logic [31:0] s_rdata;

    // Observations of the bus made by the monitor.
    int  att = -1;
    int  cur_len = 0;
    int  gap = 0;
    bit  gap_active = 1'b0;
    int  len_q [$];
    int  gap_q [$];
    bit  bus_bad = 1'b0;
    bit  ready_bad = 1'b0;
    bit  busy = 1'b0;

    logic        e_we;
    logic [21:0] e_adr;
    logic [31:0] e_dat;
    logic [3:0]  e_sel;

    // Expected results from the reference model.
    int          exp_lens [$];
    int          exp_total;
    logic [1:0]  exp_status;
    logic [31:0] exp_dat;
    int          exp_fail = 0;

    // Slave and bus monitor: drives terminations for the next rising edge,
    // measures CYC-high phase lengths and CYC-low gaps between phases, and
    // flags wrong bus values or cmd_ready during a command.
    always @(negedge clk) begin
        s_ack = 1'b0;
        s_err = 1'b0;
        s_rty = 1'b0;
        dat_i = $urandom;
        if (busy && cmd_ready_o) ready_bad = 1'b1;
        if (cyc_o) begin
            if (cur_len == 0) begin
                if (gap_active) begin
                    gap_q.push_back(gap);
                    gap_active = 1'b0;
                end
                att++;
            end
            cur_len++;
            if (stb_o !== 1'b1 || we_o !== e_we || adr_o !== e_adr ||
                sel_o !== e_sel || dat_o !== (e_we ? e_dat : 32'h0))
                bus_bad = 1'b1;
            if (att >= 0 && att < 8 && cur_len == s_dly[att]) begin
                case (s_kind[att])
                    K_ACK:    s_ack = 1'b1;
                    K_ERR:    s_err = 1'b1;
                    K_RTY:    s_rty = 1'b1;
                    K_ERRACK: begin s_err = 1'b1; s_ack = 1'b1; end
                    K_RTYACK: begin s_rty = 1'b1; s_ack = 1'b1; end
                    default:  ;
                endcase
                if (s_ack) dat_i = s_rdata;
            end
        end else begin
            if (cur_len > 0) begin
                len_q.push_back(cur_len);
                cur_len    = 0;
                gap_active = 1'b1;
                gap        = 1;
            end else if (gap_active) begin
                gap++;
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_slave(input int kind, input int dly);
        for (int i = 0; i < 8; i++) begin
            s_kind[i] = kind;
            s_dly[i]  = dly;
        end
    endtask

    // Walk the attempt script: each attempt lasts until its termination or
    // the timeout; RTY buys a back-off and another attempt while retries
    // remain. Total latency counts edges from command transfer to response.
    task automatic model_cmd(input logic we);
        exp_lens.delete();
        exp_total  = 0;
        exp_status = STATUS_ACK;
        exp_dat    = 32'h0;
        for (int a = 0; a <= MAXR; a++) begin
            if (s_kind[a] == K_NONE || s_dly[a] > TIMEOUT) begin
                exp_lens.push_back(TIMEOUT);
                exp_total += TIMEOUT;
                exp_status = STATUS_TIMEOUT;
                break;
            end
            exp_lens.push_back(s_dly[a]);
            exp_total += s_dly[a];
            if (s_kind[a] == K_ERR || s_kind[a] == K_ERRACK) begin
                exp_status = STATUS_ERR;
                break;
            end
            if (s_kind[a] == K_ACK) begin
                exp_status = STATUS_ACK;
                exp_dat    = we ? 32'h0 : s_rdata;
                break;
            end
            if (a < MAXR) begin
                exp_total += BACKOFF;
            end else begin
                exp_status = STATUS_RETRY_EXHAUSTED;
                break;
            end
        end
        if (exp_status != STATUS_ACK && exp_fail < 65535) exp_fail++;
    endtask

    // One full command: transfer, wait for the response (bounded), hold
    // rsp_ready low for 'hold' cycles, then take the response and compare.
    task automatic apply_stimulus(input logic we, input logic [21:0] adr,
                                  input logic [31:0] dat, input logic [3:0] sel,
                                  input int hold);
        int          lat;
        int          w;
        bit          stable;
        logic [1:0]  st0;
        logic [31:0] d0;
        e_we = we; e_adr = adr; e_dat = dat; e_sel = sel;
        len_q.delete();
        gap_q.delete();
        att = -1; cur_len = 0; gap_active = 1'b0;
        bus_bad = 1'b0; ready_bad = 1'b0;
        model_cmd(we);

        @(negedge clk); #1;
        w = 0;
        while (cmd_ready_o !== 1'b1 && w < 50) begin
            @(negedge clk); #1;
            w++;
        end
        check_output("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_dat   = $urandom;
        busy      = 1'b1;

        lat = 0;
        while (rsp_valid_o !== 1'b1 && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        check_output("latency", 32'(lat), 32'(exp_total));
        @(negedge clk); #1;

        st0 = rsp_status_o;
        d0  = rsp_dat_o;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_valid_o !== 1'b1 || rsp_status_o !== st0 || rsp_dat_o !== d0 ||
                cmd_ready_o !== 1'b0)
                stable = 1'b0;
        end
        check_output("rsp_stable", 32'(stable), 32'd1);
        check_output("rsp_status", 32'(rsp_status_o), 32'(exp_status));
        check_output("rsp_dat", rsp_dat_o, exp_dat);
        check_output("fail_count", 32'(fail_count_o), 32'(exp_fail));
        check_output("bus_values", 32'(bus_bad), 32'd0);
        check_output("ready_busy", 32'(ready_bad), 32'd0);

        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        busy      = 1'b0;
        check_output("rsp_valid_after", 32'(rsp_valid_o), 32'd0);
        check_output("cmd_ready_after", 32'(cmd_ready_o), 32'd1);

        check_output("phase_count", 32'(len_q.size()), 32'(exp_lens.size()));
        for (int i = 0; i < exp_lens.size(); i++)
            check_output("phase_len", (i < len_q.size()) ? 32'(len_q[i]) : 32'hFFFF_FFFF,
                         32'(exp_lens[i]));
        for (int i = 0; i + 1 < exp_lens.size(); i++)
            check_output("backoff_gap", (i < gap_q.size()) ? 32'(gap_q[i]) : 32'hFFFF_FFFF,
                         32'(BACKOFF));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  r;
        bit  seen;
        set_slave(K_NONE, 1);
        s_rdata = 32'h0;
        e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;

        // Reset values while reset is held.
        #2;
        check_output("rst_cyc", 32'(cyc_o), 32'd0);
        check_output("rst_stb", 32'(stb_o), 32'd0);
        check_output("rst_we", 32'(we_o), 32'd0);
        check_output("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check_output("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        check_output("rst_adr", 32'(adr_o), 32'd0);
        check_output("rst_dat", dat_o, 32'd0);
        check_output("rst_sel", 32'(sel_o), 32'd0);
        check_output("rst_rsp_dat", rsp_dat_o, 32'd0);
        check_output("rst_rsp_status", 32'(rsp_status_o), 32'd0);
        check_output("rst_fail_count", 32'(fail_count_o), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check_output("ready_before_edge", 32'(cmd_ready_o), 32'd0);
        @(posedge clk); #1;
        check_output("ready_first_edge", 32'(cmd_ready_o), 32'd1);

        $display("[TB] read with ACK on third bus cycle");
        set_slave(K_ACK, 3);
        s_rdata = 32'hDEADBEEF;
        apply_stimulus(1'b0, 22'h010004, 32'h0, 4'hF, 0);

        $display("[TB] write with immediate ACK");
        set_slave(K_ACK, 1);
        s_rdata = 32'hCAFEF00D;
        apply_stimulus(1'b1, 22'h030010, 32'h12345678, 4'hF, 0);

        $display("[TB] RTY on every attempt");
        set_slave(K_RTY, 2);
        apply_stimulus(1'b0, 22'h000123, 32'h0, 4'h3, 1);

        $display("[TB] no termination, timeout");
        set_slave(K_NONE, 1);
        apply_stimulus(1'b1, 22'h3FFFFF, 32'hA5A5A5A5, 4'h1, 0);

        // A stray ACK while idle must not start or finish anything.
        @(negedge clk);
        inj_ack = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (cyc_o !== 1'b0 || rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) seen = 1'b1;
        end
        inj_ack = 1'b0;
        check_output("late_ack_ignored", 32'(seen), 32'd0);
        check_output("late_ack_fail_count", 32'(fail_count_o), 32'(exp_fail));

        $display("[TB] ERR and ACK together, response held");
        set_slave(K_ERRACK, 1);
        s_rdata = 32'h11112222;
        apply_stimulus(1'b0, 22'h000200, 32'h0, 4'hC, 10);

        $display("[TB] reset in the middle of a bus phase");
        set_slave(K_NONE, 1);
        e_we = 1'b0; e_adr = 22'h00ABCD; e_dat = 32'h0; e_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 22'h00ABCD; cmd_sel = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check_output("cyc_before_reset", 32'(cyc_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("async_cyc", 32'(cyc_o), 32'd0);
        check_output("async_stb", 32'(stb_o), 32'd0);
        check_output("async_cmd_ready", 32'(cmd_ready_o), 32'd0);
        check_output("async_fail_count", 32'(fail_count_o), 32'd0);
        exp_fail = 0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid_o !== 1'b0 || cyc_o !== 1'b0) seen = 1'b1;
        end
        check_output("no_rsp_after_reset", 32'(seen), 32'd0);

        set_slave(K_ACK, 2);
        s_rdata = 32'h0BADC0DE;
        apply_stimulus(1'b0, 22'h00ABCD, 32'h0, 4'hF, 0);

        $display("[TB] randomized commands");
        for (int n = 0; n < 25; n++) begin
            for (int a = 0; a < 8; a++) begin
                r = $urandom_range(0, 99);
                s_kind[a] = (r < 3)  ? K_NONE :
                            (r < 45) ? K_ACK  :
                            (r < 60) ? K_ERR  :
                            (r < 88) ? K_RTY  :
                            (r < 94) ? K_ERRACK : K_RTYACK;
                s_dly[a] = $urandom_range(1, 6);
            end
            s_rdata = $urandom;
            apply_stimulus(1'($urandom_range(0, 1)), 22'($urandom), $urandom,
                           4'($urandom), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wbm_cmd_master.md
WBM_CMD_MASTER -- requirements
Module: wbm_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles a bus phase waits for a termination before abort; range 1..65535.
REQ-002 Parameter MAX_RETRY, default 3: number of RTY-triggered reissues allowed per command; 0 means no reissue.
REQ-003 Parameter RETRY_BACKOFF, default 4: idle cycles (CYC low) between an RTY and the reissue; range 1..255.
REQ-004 clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid_i  in  1 / cmd_ready_o  out  1  command handshake; transfer when both are high on a clock edge.
REQ-007 cmd_we_i  in  1 / cmd_adr_i  in  22 / cmd_dat_i  in  32 / cmd_sel_i  in  4  command write flag, word address, write data, byte selects.
REQ-008 rsp_valid_o  out  1 / rsp_ready_i  in  1  response handshake.
REQ-009 rsp_dat_o  out  32  read data; 0 for writes and failed commands.
REQ-010 rsp_status_o  out  2  00 ACK, 01 ERR, 10 TIMEOUT, 11 RETRY_EXHAUSTED.
REQ-011 cyc_o, stb_o, we_o  out  1 each; adr_o  out  22; dat_o  out  32; sel_o  out  4  WISHBONE classic master outputs, all registered.
REQ-012 dat_i  in  32; ack_i, err_i, rty_i  in  1 each  WISHBONE master inputs (interconnect muxed return path).
REQ-013 fail_count_o  out  16  count of commands completing with non-ACK status, saturating at 0xFFFF.

Function
REQ-014 States: IDLE, BUS, BACKOFF, RESP; encoding is free.
REQ-015 IDLE: cmd_ready_o=1; all other states: cmd_ready_o=0.
REQ-016 On a command transfer, capture we/adr/dat/sel, clear the retry and timeout counters, and enter BUS; cyc_o=stb_o=1 on the cycle after the transfer edge.
REQ-017 BUS: cyc_o=stb_o=1; we_o/adr_o/dat_o/sel_o hold the captured values; when we=0, dat_o=0.
REQ-018 Termination priority in a single sample: err_i > rty_i > ack_i.
REQ-019 ack_i in BUS: capture dat_i if read (0 if write), status ACK, enter RESP; cyc_o/stb_o low the next cycle.
REQ-020 err_i in BUS: status ERR, rsp_dat=0, enter RESP.
REQ-021 rty_i in BUS with retry count < MAX_RETRY: increment the count and enter BACKOFF; otherwise status RETRY_EXHAUSTED and enter RESP.
REQ-022 BACKOFF: cyc_o=stb_o=0 for exactly RETRY_BACKOFF cycles so the arbiter can grant other masters, then reenter BUS with the same captured values and the timeout counter cleared.
REQ-023 Timeout counter: increments each BUS cycle without termination; when it reaches TIMEOUT_CYCLES, cyc_o/stb_o drop the next cycle, status TIMEOUT, enter RESP; a termination in that same cycle takes precedence over the timeout.
REQ-024 Termination inputs outside BUS are ignored.
REQ-025 RESP: rsp_valid_o=1 with status and data stable until rsp_ready_i; on the handshake edge enter IDLE; back-to-back commands are therefore separated by at least one IDLE cycle.
REQ-026 fail_count_o increments once per non-ACK completion, at entry to RESP, and does not wrap.
REQ-027 Bus latency: an ACK on the first BUS cycle yields rsp_valid_o on the cycle after the ACK; minimum command-to-response is 2 cycles.

Reset
REQ-028 rst_n_i low immediately forces IDLE with cyc_o, stb_o, we_o, rsp_valid_o, and cmd_ready_o all 0, and adr_o, dat_o, sel_o, rsp_dat_o, rsp_status_o, fail_count_o, and all counters at 0.
REQ-029 cmd_ready_o rises on the first clock edge after rst_n_i deasserts.
REQ-030 A reset mid-cycle drops cyc_o immediately, discards the in-flight command, and produces no response.

Structure
REQ-031 Status codes (ACK/ERR/TIMEOUT/RETRY_EXHAUSTED) and WISHBONE widths (22/32/4) are shared header constants, next to the existing wishbone macros.
REQ-032 A single module with no sub-modules; the timeout/backoff counter is one shared 16-bit register.

Verification
REQ-033 Read 0x010004, slave ACKs on the 3rd BUS cycle with 0xDEADBEEF -> rsp_status 00, rsp_dat 0xDEADBEEF, cyc_o high exactly 3 cycles.
REQ-034 Write 0x030010 data 0x12345678 sel 0xF, immediate ACK -> adr/dat/sel/we are correct on the bus, rsp_dat 0, status 00, fail_count unchanged.
REQ-035 Slave asserts rty_i on every attempt with MAX_RETRY=3 and RETRY_BACKOFF=4 -> 4 bus phases, each separated by 4 CYC-low cycles, then status 11 and fail_count +1.
REQ-036 No termination with TIMEOUT_CYCLES=255 -> cyc_o drops after 255 BUS cycles, status 10; a late ack_i in IDLE is ignored.
REQ-037 err_i and ack_i together -> status 01; rsp_ready_i held low for 10 cycles -> rsp_valid_o and rsp_status_o stay stable, cmd_ready_o stays 0.
REQ-038 rst_n_i pulsed low mid-BUS -> cyc_o is 0 asynchronously, no rsp_valid_o, and the next command completes normally.
